// File: rtl/spi_pkg.sv
// Shared types and defaults for the clocked SPI responder.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DW_DEF          = 8;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer with async reset to a per-instance value.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_s_sync.sv
// SPI responder running on clk: oversampled sclk/cs/sdi, LSB-first in both
// directions, one-word holding register for the response path.
module spi_s_sync
    import spi_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          cs,
    input  logic          sdi,
    output logic          sdo,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          tx_underrun,
    output logic          frame_err,
    output logic          busy
);

    localparam int CW = $clog2(DW);

    logic          sclk_s, cs_s, sdi_s, sclk_s_d;
    logic          sclk_fall;
    state_t        state, state_nxt;
    logic [CW-1:0] bit_cnt;
    logic [DW-1:0] hold, tx_sh, load_word;
    logic [DW-2:0] rx_sh;
    logic          hold_full, accept, word_done_d;
    logic          start, abort, shift_en, last, load;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs), .q(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst(rst), .d(sdi), .q(sdi_s)
    );

    assign sclk_fall = ~sclk_s & sclk_s_d;
    assign tx_ready  = ~hold_full;
    assign accept    = tx_valid & ~hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!cs_s) state_nxt = SHIFT;
            SHIFT:   if (cs_s)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start     = (state == IDLE) && !cs_s;
        abort     = (state == SHIFT) && cs_s;
        shift_en  = (state == SHIFT) && !cs_s && sclk_fall;
        last      = shift_en && (bit_cnt == CW'(DW - 1));
        load      = start || last;
        load_word = hold_full ? hold : '0;
        busy      = (state == SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s_d    <= 1'b0;
            hold        <= '0;
            hold_full   <= 1'b0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            rx_data     <= '0;
            bit_cnt     <= '0;
            sdo         <= 1'b0;
            word_done_d <= 1'b0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sclk_s_d    <= sclk_s;
            word_done_d <= last;
            rx_valid    <= word_done_d;
            tx_underrun <= load && !hold_full;
            frame_err   <= abort && (bit_cnt != '0);

            // A load that empties a full hold blocks accept that cycle (tx_ready=0).
            if (accept) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load) begin
                tx_sh   <= load_word;
                sdo     <= load_word[0];
                bit_cnt <= '0;
            end else if (abort) begin
                sdo     <= 1'b0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + CW'(1);
                tx_sh   <= {tx_sh[0], tx_sh[DW-1:1]};
                sdo     <= tx_sh[1];
            end

            if (shift_en) begin
                rx_sh <= {sdi_s, rx_sh[DW-2:1]};
            end
            if (last) begin
                rx_data <= {sdi_s, rx_sh};
            end
        end
    end

endmodule

// File: tb/tb_spi_s_sync.sv
// Directed bench for spi_s_sync: bit-banged SPI master with sclk = clk/8.
module tb_spi_s_sync;

    logic       clk = 1'b0;
    logic       rst, sclk, cs, sdi, sdo;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, tx_underrun, frame_err, busy;

    int checks   = 0;
    int failures = 0;
    int rx_cnt   = 0;
    int ur_cnt   = 0;
    int fe_cnt   = 0;
    logic [7:0] rx_hist[$];

    spi_s_sync #(.DW(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .sdi(sdi), .sdo(sdo),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            rx_hist.push_back(rx_data);
        end
        if (tx_underrun) ur_cnt++;
        if (frame_err)   fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        int n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_timeout", n < 50, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            sclk  = 1'b1;
            mi[i] = sdo;
            sdi   = mo[i];
            wait_clk(4);
            sclk  = 1'b0;
            wait_clk(4);
        end
    endtask

    initial begin
        logic [7:0] mi0, mi1;
        int rc0, ur0, fe0;

        rst = 1'b1; sclk = 1'b0; cs = 1'b1; sdi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(20);
        chk("idle_sdo", sdo, 0);
        chk("idle_tx_ready", tx_ready, 1);
        chk("idle_rx_valid", rx_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_rx_data", rx_data, 0);

        // single word: respond A5, receive 3C
        load_tx(8'hA5);
        chk("hold_full_ready", tx_ready, 0);
        rc0 = rx_cnt; ur0 = ur_cnt; fe0 = fe_cnt;
        cs = 1'b0;
        wait_clk(4);
        chk("busy_in_frame", busy, 1);
        xfer(8'h3C, 8, mi0);
        cs = 1'b1;
        wait_clk(8);
        chk("w1_rx_pulses", rx_cnt - rc0, 1);
        chk("w1_rx_data", rx_data, 8'h3C);
        chk("w1_master_rx", mi0, 8'hA5);
        chk("w1_tx_ready", tx_ready, 1);
        chk("w1_frame_err", fe_cnt - fe0, 0);
        chk("w1_underrun_tail", ur_cnt - ur0, 1);
        chk("w1_busy_end", busy, 0);

        // two words in one frame
        load_tx(8'h11);
        rc0 = rx_cnt; ur0 = ur_cnt;
        cs = 1'b0;
        wait_clk(4);
        load_tx(8'h22);
        xfer(8'h81, 8, mi0);
        xfer(8'h7E, 8, mi1);
        cs = 1'b1;
        wait_clk(8);
        chk("w2_rx_pulses", rx_cnt - rc0, 2);
        chk("w2_rx_first", rx_hist[rc0], 8'h81);
        chk("w2_rx_second", rx_hist[rc0+1], 8'h7E);
        chk("w2_master_rx0", mi0, 8'h11);
        chk("w2_master_rx1", mi1, 8'h22);
        chk("w2_underrun_tail", ur_cnt - ur0, 1);

        // underrun: nothing loaded
        rc0 = rx_cnt; ur0 = ur_cnt;
        cs = 1'b0;
        wait_clk(4);
        chk("w3_underrun_at_cs", ur_cnt - ur0, 1);
        xfer(8'hC3, 8, mi0);
        cs = 1'b1;
        wait_clk(8);
        chk("w3_master_rx", mi0, 8'h00);
        chk("w3_rx_data", rx_data, 8'hC3);
        chk("w3_rx_pulses", rx_cnt - rc0, 1);
        chk("w3_underrun_total", ur_cnt - ur0, 2);

        // cs rises after 3 bits
        rc0 = rx_cnt; fe0 = fe_cnt;
        cs = 1'b0;
        wait_clk(4);
        xfer(8'hFF, 3, mi0);
        cs = 1'b1;
        wait_clk(8);
        chk("fe_pulses", fe_cnt - fe0, 1);
        chk("fe_no_rx_valid", rx_cnt - rc0, 0);
        chk("fe_busy", busy, 0);
        chk("fe_rx_data_kept", rx_data, 8'hC3);
        cs = 1'b0;
        wait_clk(4);
        xfer(8'hF0, 8, mi0);
        cs = 1'b1;
        wait_clk(8);
        chk("fe_next_rx_data", rx_data, 8'hF0);
        chk("fe_next_pulses", rx_cnt - rc0, 1);
        chk("fe_no_more_err", fe_cnt - fe0, 1);

        // reset in the middle of a word
        load_tx(8'h33);
        rc0 = rx_cnt; fe0 = fe_cnt;
        cs = 1'b0;
        wait_clk(4);
        xfer(8'hAA, 5, mi0);
        rst = 1'b1; cs = 1'b1;
        #1;
        chk("rst_sdo", sdo, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_pulses", {rx_valid, tx_underrun, frame_err}, 3'b000);
        wait_clk(1);
        rst = 1'b0;
        wait_clk(10);
        chk("rst_no_frame_err", fe_cnt - fe0, 0);
        chk("rst_no_rx_valid", rx_cnt - rc0, 0);
        load_tx(8'h5A);
        cs = 1'b0;
        wait_clk(4);
        xfer(8'h96, 8, mi0);
        cs = 1'b1;
        wait_clk(8);
        chk("post_rst_rx_data", rx_data, 8'h96);
        chk("post_rst_master_rx", mi0, 8'h5A);
        chk("post_rst_pulses", rx_cnt - rc0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
